atm_pin_entry: RTL

//  Keypad PIN-collection and verification stage upstream of the ATM controller (tubes).

---
 rtl/atm_pin_entry_if.sv | 24 ++
 rtl/atm_pin_entry.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/atm_pin_entry_if.sv
// Signal bundle between the keypad/card reader side and the PIN entry stage,
// including the status outputs consumed by the ATM controller.
interface atm_pin_entry_if;
  logic       card_inserted;
  logic       key_valid;
  logic [3:0] key_code;
  logic       pin_entered;
  logic       pin_correct;
  logic [2:0] state;
  logic [2:0] digit_count;
  logic [1:0] tries_left;
  logic       locked;
  logic       timeout;

  modport master (
    output card_inserted, key_valid, key_code,
    input  pin_entered, pin_correct, state, digit_count, tries_left, locked, timeout
  );

  modport slave (
    input  card_inserted, key_valid, key_code,
    output pin_entered, pin_correct, state, digit_count, tries_left, locked, timeout
  );
endinterface

// File: rtl/atm_pin_entry.sv
// Keypad PIN collection, comparison against a stored BCD PIN, retry limit and lockout.
// Optional idle-entry timeout is built only when PIN_TIMEOUT_EN is defined.
//
// state     | meaning
// ----------+---------------------------------------------------------
// S_IDLE    | no card; keys ignored
// S_COLLECT | buffering digits, waiting for ENTER with a full buffer
// S_CHECK   | one-cycle compare; pin_entered pulses on the next edge
// S_DONE    | PIN accepted; held until the card is removed
// S_LOCKED  | retry limit exhausted; held until the card is removed
module atm_pin_entry #(
  parameter int                      PIN_DIGITS  = 4,
  parameter int                      MAX_TRIES   = 3,
  parameter logic [4*PIN_DIGITS-1:0] STORED_PIN  = 16'h1234,
  parameter int                      TIMEOUT_CYC = 1000
) (
  input  logic           clk,
  input  logic           reset,
  atm_pin_entry_if.slave bus
);

  localparam int         BW         = 4 * PIN_DIGITS;
  localparam logic [2:0] FULL       = 3'(PIN_DIGITS);
  localparam logic [1:0] TRIES_INIT = 2'(MAX_TRIES);

  if (PIN_DIGITS < 1 || PIN_DIGITS > 6) begin : g_bad_pin_digits
    $error("atm_pin_entry: PIN_DIGITS must be 1..6");
  end
  if (MAX_TRIES < 1 || MAX_TRIES > 3) begin : g_bad_max_tries
    $error("atm_pin_entry: MAX_TRIES must be 1..3");
  end
  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("atm_pin_entry: TIMEOUT_CYC must be >= 2");
  end

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_CHECK   = 3'd2,
    S_DONE    = 3'd3,
    S_LOCKED  = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] buf_q, buf_d;
  logic [2:0]    count_q, count_d;
  logic [1:0]    tries_q, tries_d;
  logic          pe_q, pe_d;
  logic          pc_q, pc_d;
  logic          to_q, to_d;

  logic key_digit;
  logic key_clear;
  logic key_enter;
  logic pin_match;
  logic timeout_hit;

  assign key_digit = bus.key_valid && (bus.key_code <= 4'd9);
  assign key_clear = bus.key_valid && (bus.key_code == 4'hA);
  assign key_enter = bus.key_valid && (bus.key_code == 4'hB);
  assign pin_match = (buf_q == STORED_PIN);

`ifdef PIN_TIMEOUT_EN
  // Down-counter reloaded on every key and outside COLLECT; expiry at zero
  // lands exactly TIMEOUT_CYC idle cycles after the last key.
  localparam int            CW      = $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0] TC_LOAD = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] idle_q, idle_d;

  always_comb begin
    idle_d = TC_LOAD;
    if (state_q == S_COLLECT && bus.card_inserted && !bus.key_valid && idle_q != '0)
      idle_d = idle_q - 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) idle_q <= TC_LOAD;
    else        idle_q <= idle_d;
  end

  assign timeout_hit = (state_q == S_COLLECT) && !bus.key_valid && (idle_q == '0);
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    count_d = count_q;
    tries_d = tries_q;
    pe_d    = 1'b0;
    pc_d    = 1'b0;
    to_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.card_inserted) begin
          state_d = S_COLLECT;
          buf_d   = '0;
          count_d = '0;
          tries_d = TRIES_INIT;
        end
      end

      S_COLLECT: begin
        if (!bus.card_inserted) begin
          state_d = S_IDLE;
          buf_d   = '0;
          count_d = '0;
        end else if (key_digit) begin
          if (count_q < FULL) begin
            buf_d      = buf_q << 4;
            buf_d[3:0] = bus.key_code;
            count_d    = count_q + 3'd1;
          end
        end else if (key_clear) begin
          buf_d   = '0;
          count_d = '0;
        end else if (key_enter) begin
          if (count_q == FULL) state_d = S_CHECK;
        end else if (timeout_hit) begin
          buf_d   = '0;
          count_d = '0;
          to_d    = 1'b1;
        end
      end

      S_CHECK: begin
        // The result pulse is emitted even when the card leaves in this cycle.
        pe_d    = 1'b1;
        pc_d    = pin_match;
        buf_d   = '0;
        count_d = '0;
        if (!pin_match && tries_q != 2'd0) tries_d = tries_q - 2'd1;
        if (!bus.card_inserted)  state_d = S_IDLE;
        else if (pin_match)      state_d = S_DONE;
        else if (tries_q <= 2'd1) state_d = S_LOCKED;
        else                     state_d = S_COLLECT;
      end

      S_DONE: begin
        if (!bus.card_inserted) state_d = S_IDLE;
      end

      S_LOCKED: begin
        tries_d = '0;
        if (!bus.card_inserted) state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        buf_d   = '0;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      buf_q   <= '0;
      count_q <= '0;
      tries_q <= TRIES_INIT;
      pe_q    <= 1'b0;
      pc_q    <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      count_q <= count_d;
      tries_q <= tries_d;
      pe_q    <= pe_d;
      pc_q    <= pc_d;
      to_q    <= to_d;
    end
  end

  assign bus.state       = state_q;
  assign bus.digit_count = count_q;
  assign bus.tries_left  = tries_q;
  assign bus.pin_entered = pe_q;
  assign bus.pin_correct = pc_q;
  assign bus.locked      = (state_q == S_LOCKED);
  assign bus.timeout     = to_q;

endmodule
